pow_n_pipe: RTL and testbench

POW_N_PIPE -- requirements
Module: pow_n_pipe

---
 rtl/pow_n_pipe.sv | 110 +++++++++++
 tb/tb_pow_n_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pow_n_pipe.sv
// Pipelined x^(2^k) unit: a chain of squaring stages with per-stage valid/ready
// handshaking so bubbles collapse and a full pipe can still stream at one beat per cycle.
module pow_n_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OUT_W  = 64,
  parameter int unsigned STAGES = 3,
  parameter int unsigned ID_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_W-1:0]            s_data,
  input  logic [$clog2(STAGES+1)-1:0]  s_shift,
  input  logic [ID_W-1:0]              s_id,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [OUT_W-1:0]             m_data,
  output logic [ID_W-1:0]              m_id,
  output logic                         busy
);

  localparam int unsigned SHIFT_W = $clog2(STAGES + 1);
  localparam int unsigned EXT_W   = SHIFT_W + 1;

  logic [STAGES-1:0]  r_valid;
  logic [OUT_W-1:0]   r_data  [STAGES];
  logic [SHIFT_W-1:0] r_shift [STAGES];
  logic [ID_W-1:0]    r_id    [STAGES];

  logic [STAGES-1:0]  w_ready;
  logic               w_all_full;
  logic [EXT_W-1:0]   w_shift_ext;
  logic [SHIFT_W-1:0] w_shift_sat;

  logic [STAGES-1:0]  w_in_valid;
  logic [OUT_W-1:0]   w_in_data  [STAGES];
  logic [SHIFT_W-1:0] w_in_shift [STAGES];
  logic [ID_W-1:0]    w_in_id    [STAGES];
  logic [OUT_W-1:0]   w_nxt_data [STAGES];

  // Exponents beyond the pipeline depth clamp to the deepest one.
  always_comb begin
    w_shift_ext = {1'b0, s_shift};
    w_shift_sat = (w_shift_ext > EXT_W'(STAGES)) ? SHIFT_W'(STAGES) : s_shift;
  end

  // Stage i may load unless it and every stage after it are full while m_ready is low.
  always_comb begin
    w_ready    = '0;
    w_all_full = 1'b1;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_all_full = w_all_full & r_valid[i];
      w_ready[i] = m_ready | ~w_all_full;
    end
  end

  // Operand entering each stage, squared on the way in when the stage index is below k.
  always_comb begin
    w_in_valid = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_in_data[i]  = '0;
      w_in_shift[i] = '0;
      w_in_id[i]    = '0;
      w_nxt_data[i] = '0;
    end
    w_in_valid[0] = s_valid;
    w_in_data[0]  = OUT_W'(s_data);
    w_in_shift[0] = w_shift_sat;
    w_in_id[0]    = s_id;
    for (int i = 1; i < STAGES; i++) begin
      w_in_valid[i] = r_valid[i-1];
      w_in_data[i]  = r_data[i-1];
      w_in_shift[i] = r_shift[i-1];
      w_in_id[i]    = r_id[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      w_nxt_data[i] = (w_in_shift[i] > SHIFT_W'(i)) ? w_in_data[i] * w_in_data[i]
                                                     : w_in_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (w_ready[i]) r_valid[i] <= w_in_valid[i];
      end
    end
  end

  // Payload registers carry no reset; they are only meaningful alongside r_valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (w_ready[i] && w_in_valid[i]) begin
        r_data[i]  <= w_nxt_data[i];
        r_shift[i] <= w_in_shift[i];
        r_id[i]    <= w_in_id[i];
      end
    end
  end

  assign s_ready = w_ready[0];
  assign m_valid = r_valid[STAGES-1];
  assign m_data  = r_data[STAGES-1];
  assign m_id    = r_id[STAGES-1];
  assign busy    = |r_valid;

endmodule

// File: tb/tb_pow_n_pipe.sv
// Scoreboard bench for pow_n_pipe: the driver queues expected results on accept,
// an independent monitor pops and compares on every output transfer.
module tb_pow_n_pipe;

  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   s_data;
  logic [SW-1:0] s_shift;
  logic [7:0]    s_id;
  logic          m_valid;
  logic          m_ready;
  logic [63:0]   m_data;
  logic [7:0]    m_id;
  logic          busy;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  id;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  bit   rdy_rand  = 1'b0;
  logic rdy_fixed = 1'b1;

  pow_n_pipe dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_shift(s_shift), .s_id(s_id),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_id(m_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, req);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0b want=%0b", nm, act, req);
    end
  endtask

  // Called at a rising edge; returns at the rising edge on which the beat was accepted.
  task automatic send(input logic [31:0] x, input logic [SW-1:0] k, input logic [7:0] id,
                      input logic [63:0] e_val, input bit push);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    #1;
    s_valid = 1'b1;
    s_data  = x;
    s_shift = k;
    s_id    = id;
    while (!ok) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      if (ok && push) q.push_back('{d: e_val, id: id});
      n++;
      if (!ok && n > 500) begin
        total++;
        bad++;
        $display("FAIL send_timeout: id=%0h not accepted", id);
        ok = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    #1;
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check(nm, 64'(q.size()), 64'(0));
  endtask

  // Output handshake driver.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  // Monitor: the transfer will happen on the next rising edge when both are high here.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && m_valid && m_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got data=%0h id=%0h want none", m_data, m_id);
        end else begin
          mon_e = q.pop_front();
          check("m_data", m_data, mon_e.d);
          check("m_id", 64'(m_id), 64'(mon_e.id));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] xv;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_shift = '0;
    s_id    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("rst_m_valid", m_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_s_ready", s_ready, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);

    // Latency: accepted at edge T, visible after T+2.
    send(32'd3, SW'(3), 8'h01, 64'd6561, 1'b1);
    idle(0);
    @(negedge clk); check1("lat_t0", m_valid, 1'b0);
    @(posedge clk); @(negedge clk); check1("lat_t1", m_valid, 1'b0);
    @(posedge clk); @(negedge clk); check1("lat_t2", m_valid, 1'b1);
    @(posedge clk);

    // Directed values, back to back.
    send(32'd2,          SW'(3), 8'h02, 64'd256, 1'b1);
    send(32'd7,          SW'(0), 8'h03, 64'd7, 1'b1);
    send(32'd3,          SW'(2), 8'h04, 64'd81, 1'b1);
    send(32'hFFFF_FFFF,  SW'(3), 8'h05, 64'hFFFF_FFF8_0000_0001, 1'b1);
    send(32'd0,          SW'(3), 8'h06, 64'd0, 1'b1);
    send(32'd2,          SW'(7), 8'h07, 64'd256, 1'b1);
    send(32'd10,         SW'(1), 8'h08, 64'd100, 1'b1);
    idle(6);
    drain("directed_drain");

    // Stream with random gaps and random backpressure.
    rdy_rand = 1'b1;
    for (int x = 0; x <= 100; x++) begin
      idle($urandom_range(0, 2));
      xv = 64'(x);
      send(32'(x), SW'(3), 8'(x), xv * xv * xv * xv * xv * xv * xv * xv, 1'b1);
    end
    idle(0);
    drain("stream_drain");
    rdy_rand  = 1'b0;
    rdy_fixed = 1'b0;
    @(posedge clk);
    @(posedge clk);

    // Full stall, then simultaneous in/out transfer.
    send(32'd3, SW'(3), 8'h10, 64'd6561, 1'b1);
    send(32'd2, SW'(3), 8'h11, 64'd256, 1'b1);
    send(32'd7, SW'(1), 8'h12, 64'd49, 1'b1);
    #1;
    s_valid = 1'b1;
    s_data  = 32'd5;
    s_shift = SW'(2);
    s_id    = 8'h13;
    repeat (3) begin
      @(negedge clk);
      check1("stall_s_ready", s_ready, 1'b0);
      check("stall_m_data", m_data, 64'd6561);
      check("stall_m_id", 64'(m_id), 64'h10);
      @(posedge clk);
    end
    rdy_fixed = 1'b1;
    @(negedge clk);
    check1("both_s_ready", s_ready, 1'b1);
    check1("both_m_valid", m_valid, 1'b1);
    @(posedge clk);
    q.push_back('{d: 64'd625, id: 8'h13});
    idle(6);
    drain("stall_drain");

    // Reset with two beats in flight; they must never appear.
    rdy_fixed = 1'b0;
    @(posedge clk);
    send(32'd9, SW'(3), 8'h20, 64'd0, 1'b0);
    send(32'd4, SW'(3), 8'h21, 64'd0, 1'b0);
    #1;
    s_valid = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check1("mid_rst_m_valid", m_valid, 1'b0);
    check1("mid_rst_busy", busy, 1'b0);
    check1("mid_rst_s_ready", s_ready, 1'b1);
    @(posedge clk);
    rdy_fixed = 1'b1;
    send(32'd5, SW'(1), 8'h22, 64'd25, 1'b1);
    idle(6);
    drain("final_drain");
    @(negedge clk);
    check1("end_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
